lms_tap_feeder: RTL and testbench

Single-clock stage directly downstream of the LMS sample prefetch FIFO. It pops 16-bit audio samples from the FIFO's prefetch read port and keeps a TAPS-deep delay line. For each new sample it streams the whole tap vector x[n], x[n-1], …, x[n-TAPS+1] one tap per beat, with valid/ready handshaking, to the serial LMS MAC/update engine.

---
 rtl/lms_tap_feeder.sv | 78 +++++++
 tb/tb_lms_tap_feeder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lms_tap_feeder.sv
// Pops samples from the LMS prefetch FIFO into a TAPS-deep delay line and
// streams the full tap vector x[n]..x[n-TAPS+1] one beat per handshake.
module lms_tap_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 32,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] tap_data,
    output logic [IDX_WIDTH-1:0]  tap_idx,
    output logic                  tap_vld,
    output logic                  tap_last,
    input  logic                  tap_rdy
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TAPS - 1);

    state_t                state;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] dline [TAPS];

    logic streaming;
    logic last_beat;
    logic pop;

    assign streaming = (state == STREAM);
    assign last_beat = streaming && (idx == LAST_IDX);

    // Re-pop only as the last beat is accepted so back-to-back bursts take exactly TAPS cycles.
    assign pop = rst_n && !flush && fifo_rd_vld &&
                 (!streaming || (tap_rdy && last_beat));

    // idx is returned to 0 on leaving STREAM, so IDLE presents dline[0] at tap 0.
    assign fifo_rd_en = pop;
    assign tap_vld    = streaming;
    assign tap_last   = last_beat;
    assign tap_idx    = idx;
    assign tap_data   = dline[idx];

    // NOTE: the delay line is reset explicitly because tap values are visible
    // outputs and early bursts must carry zeros, not power-up garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            for (int k = 0; k < TAPS; k++) dline[k] <= '0;
        end else if (flush) begin
            state <= IDLE;
            idx   <= '0;
            for (int k = 0; k < TAPS; k++) dline[k] <= '0;
        end else if (pop) begin
            // NOTE: non-blocking assignments make every dline[k] read its
            // pre-edge neighbour, so the loop order does not matter.
            for (int k = TAPS - 1; k > 0; k--) dline[k] <= dline[k-1];
            dline[0] <= fifo_rd_data;
            idx      <= '0;
            state    <= STREAM;
        end else if (streaming && tap_rdy) begin
            if (last_beat) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_lms_tap_feeder.sv
// Randomised bench for lms_tap_feeder: a queue-based history model predicts
// every output each cycle while directed phases hit reset, flush and stall cases.
module tb_lms_tap_feeder;

    localparam int DW   = 16;
    localparam int TAPS = 32;
    localparam int IW   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_vld = 1'b0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic [DW-1:0] tap_data;
    logic [IW-1:0] tap_idx;
    logic          tap_vld;
    logic          tap_last;
    logic          tap_rdy = 1'b1;

    lms_tap_feeder #(.DATA_WIDTH(DW), .TAPS(TAPS), .IDX_WIDTH(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .tap_data     (tap_data),
        .tap_idx      (tap_idx),
        .tap_vld      (tap_vld),
        .tap_last     (tap_last),
        .tap_rdy      (tap_rdy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: fifo contents, popped-sample history (newest first), burst position.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] hist[$];
    bit            in_burst = 1'b0;
    int            beat     = 0;
    int            pops     = 0;

    bit rnd_rdy = 1'b0;
    bit rnd_vld = 1'b0;
    bit rnd_flush = 1'b0;
    bit force_flush = 1'b0;
    int bp_at = -1;
    int bp_cnt = 0;
    int flush_at = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] tap_value(input int i);
        return (i < hist.size()) ? hist[i] : '0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld"},  32'(tap_vld),    32'd0);
        check({tag, "_en"},   32'(fifo_rd_en), 32'd0);
        check({tag, "_data"}, 32'(tap_data),   32'd0);
        check({tag, "_idx"},  32'(tap_idx),    32'd0);
        check({tag, "_last"}, 32'(tap_last),   32'd0);
    endtask

    // Entered at a falling edge: drive inputs, check outputs, advance the model
    // over the coming rising edge, then wait for the next falling edge.
    task automatic step();
        bit exp_en;
        bit is_last;
        int shown;

        if (rnd_vld && fifo_q.size() < 4 && $urandom_range(0, 39) == 0)
            fifo_q.push_back(DW'($urandom));

        tap_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (bp_at >= 0 && in_burst && beat == bp_at) begin
            if (bp_cnt < 3) begin
                tap_rdy = 1'b0;
                bp_cnt++;
            end else begin
                tap_rdy = 1'b1;
                bp_at = -1;
            end
        end

        flush = force_flush;
        force_flush = 1'b0;
        if (flush_at >= 0 && in_burst && beat == flush_at) begin
            flush = 1'b1;
            flush_at = -1;
        end
        if (rnd_flush && $urandom_range(0, 299) == 0) flush = 1'b1;

        fifo_rd_vld  = (fifo_q.size() > 0) && !(rnd_vld && $urandom_range(0, 2) == 0);
        fifo_rd_data = fifo_rd_vld ? fifo_q[0] : DW'($urandom);

        #1;
        is_last = in_burst && (beat == TAPS - 1);
        exp_en  = !flush && fifo_rd_vld && (!in_burst || (tap_rdy && is_last));
        shown   = in_burst ? beat : 0;

        check("tap_vld",    32'(tap_vld),    32'(in_burst));
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_en));
        check("tap_idx",    32'(tap_idx),    32'(shown));
        check("tap_last",   32'(tap_last),   32'(is_last));
        check("tap_data",   32'(tap_data),   32'(tap_value(shown)));

        if (flush) begin
            hist.delete();
            in_burst = 1'b0;
            beat = 0;
        end else if (exp_en) begin
            hist.push_front(fifo_q.pop_front());
            if (hist.size() > TAPS) void'(hist.pop_back());
            in_burst = 1'b1;
            beat = 0;
            pops++;
        end else if (in_burst && tap_rdy) begin
            if (is_last) in_burst = 1'b0;
            else beat++;
        end

        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset held with a valid FIFO head: nothing may pop, outputs at zero.
        fifo_q.push_back(16'h1234);
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 16'h1234;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single sample: one pop on the first edge, 32 beats, then idle.
        run(40);
        check("single_pops", 32'(pops), 32'd1);

        // Back-to-back from a cleared delay line: 1, 2, 3 with pops on last beats.
        force_flush = 1'b1;
        step();
        pops = 0;
        fifo_q.push_back(16'h0001);
        fifo_q.push_back(16'h0002);
        fifo_q.push_back(16'h0003);
        run(1 + 3 * TAPS + 4);
        check("b2b_pops", 32'(pops), 32'd3);
        check("b2b_hist2", 32'(tap_value(2)), 32'h0001);

        // Backpressure: stall three cycles on beat 5.
        fifo_q.push_back(DW'($urandom));
        fifo_q.push_back(DW'($urandom));
        bp_at = 5;
        bp_cnt = 0;
        run(2 * TAPS + 10);

        // Flush at beat 10 with 0x00AA waiting behind the current sample.
        fifo_q.push_back(16'h0055);
        fifo_q.push_back(16'h00AA);
        flush_at = 10;
        run(TAPS + 20);
        check("flush_hist0", 32'(tap_value(0)), 32'h00AA);
        check("flush_depth", 32'(hist.size()), 32'd1);

        // Empty FIFO for 100 cycles: nothing moves.
        pops = 0;
        run(100);
        check("empty_pops", 32'(pops), 32'd0);

        // Asynchronous reset in the middle of a burst.
        fifo_q.push_back(DW'($urandom));
        run(8);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        hist.delete();
        in_burst = 1'b0;
        beat = 0;
        fifo_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, stalls, FIFO gaps and occasional flushes.
        rnd_rdy = 1'b1;
        rnd_vld = 1'b1;
        rnd_flush = 1'b1;
        run(4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
